// File: rtl/vpll_reconfig_seq.sv
// Video PLL retune sequencer: watches the requested pixel-clock profile and drives the
// Altera PLL-reconfig mgmt port (MIF base, start), then waits for lock with bounded retries.
module vpll_reconfig_seq #(
    parameter int NUM_PROFILES = 4,
    parameter int MIF_STRIDE   = 64,
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 32,
    parameter int MIF_REG      = 31,
    parameter int START_REG    = 2,
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int RETRIES      = 2,
    localparam int SEL_W       = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
    input  logic              CLK_50M,
    input  logic              reset,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic              force_i,
    output logic [ADDR_W-1:0] mgmt_address,
    output logic [DATA_W-1:0] mgmt_writedata,
    output logic              mgmt_write,
    input  logic              mgmt_waitrequest,
    input  logic              pll_locked,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [SEL_W-1:0]  cur_sel_o
);

    localparam int TMR_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam int ATT_W = $clog2(RETRIES + 1) + 1;
    localparam logic [SEL_W:0] NUM_P = (SEL_W + 1)'(NUM_PROFILES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_MIF,
        ST_GAP,
        ST_WR_START,
        ST_WAIT_LOCK,
        ST_RETRY,
        ST_DONE
    } state_t;

    state_t state, state_nx;

    logic [SEL_W-1:0] sel_s1, sel_s2, sel_prev, sel_cl, stable_sel;
    logic [SEL_W-1:0] pend_tgt, tgt, flight_tgt;
    logic             force_s1, force_s2, force_d;
    logic             lock_s1, lock_s2;
    logic [1:0]       init_cnt;
    logic             init_done;
    logic             pending;
    logic [TMR_W-1:0] timer;
    logic [ATT_W-1:0] attempt;
    logic [2:0]       lock_cnt;
    logic             err;
    logic             force_edge, sel_stable, sel_req, take, in_flight, req;
    logic             lock_ok, timeout, retry_left;

    // Request detection: a settled sel that moved to a new profile, or a force edge.
    always_comb begin
        sel_cl     = ({1'b0, sel_s2} >= NUM_P) ? SEL_W'(NUM_PROFILES - 1) : sel_s2;
        init_done  = (init_cnt == 2'd3);
        force_edge = force_s2 & ~force_d;
        sel_stable = (sel_s2 == sel_prev);
        sel_req    = sel_stable & (sel_cl != stable_sel) & (sel_cl != cur_sel_o);
        take       = (state == ST_IDLE) & pending & init_done;
        in_flight  = take | (state != ST_IDLE);
        flight_tgt = take ? pend_tgt : tgt;
        req        = init_done &
                     (force_edge | (sel_req & ~(in_flight & (sel_cl == flight_tgt))));
        lock_ok    = lock_s2 & (lock_cnt == 3'd3);
        timeout    = (timer == TMR_W'(LOCK_TIMEOUT - 1));
        retry_left = (attempt < ATT_W'(RETRIES));
    end

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        mgmt_address   = '0;
        mgmt_writedata = '0;
        mgmt_write     = 1'b0;
        done_o         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (take) state_nx = ST_WR_MIF;
            end
            ST_WR_MIF: begin
                mgmt_address   = ADDR_W'(MIF_REG);
                mgmt_writedata = DATA_W'(tgt) * DATA_W'(MIF_STRIDE);
                mgmt_write     = 1'b1;
                if (!mgmt_waitrequest) state_nx = ST_GAP;
            end
            ST_GAP: begin
                state_nx = ST_WR_START;
            end
            ST_WR_START: begin
                mgmt_address = ADDR_W'(START_REG);
                mgmt_write   = 1'b1;
                if (!mgmt_waitrequest) state_nx = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_ok)      state_nx = ST_DONE;
                else if (timeout) state_nx = ST_RETRY;
            end
            ST_RETRY: begin
                state_nx = retry_left ? ST_WR_MIF : ST_IDLE;
            end
            ST_DONE: begin
                done_o   = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Synchronisers and the single-entry request latch; the first 3 cycles after reset
    // only load the reload target once the synchronised sel has become valid.
    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            sel_s1     <= '0;
            sel_s2     <= '0;
            sel_prev   <= '0;
            stable_sel <= '0;
            force_s1   <= 1'b0;
            force_s2   <= 1'b0;
            force_d    <= 1'b0;
            lock_s1    <= 1'b0;
            lock_s2    <= 1'b0;
            init_cnt   <= 2'd0;
            pending    <= 1'b1;
            pend_tgt   <= '0;
        end else begin
            sel_s1   <= sel_i;
            sel_s2   <= sel_s1;
            sel_prev <= sel_s2;
            force_s1 <= force_i;
            force_s2 <= force_s1;
            force_d  <= force_s2;
            lock_s1  <= pll_locked;
            lock_s2  <= lock_s1;
            if (!init_done) begin
                init_cnt   <= init_cnt + 2'd1;
                pend_tgt   <= sel_cl;
                stable_sel <= sel_cl;
            end else begin
                if (sel_stable) stable_sel <= sel_cl;
                if (req) begin
                    pending  <= 1'b1;
                    pend_tgt <= sel_cl;
                end else if (take) begin
                    pending <= 1'b0;
                end
            end
        end
    end

    // Sequence datapath: target, attempt count, lock timer and confirm counter.
    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            tgt       <= '0;
            attempt   <= '0;
            timer     <= '0;
            lock_cnt  <= 3'd0;
            err       <= 1'b0;
            cur_sel_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        tgt     <= pend_tgt;
                        attempt <= '0;
                    end
                end
                ST_WR_START: begin
                    if (!mgmt_waitrequest) begin
                        timer    <= '0;
                        lock_cnt <= 3'd0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (!timeout) timer <= timer + TMR_W'(1);
                    if (!lock_s2)              lock_cnt <= 3'd0;
                    else if (lock_cnt != 3'd3) lock_cnt <= lock_cnt + 3'd1;
                end
                ST_RETRY: begin
                    if (retry_left) attempt <= attempt + ATT_W'(1);
                    else            err     <= 1'b1;
                end
                ST_DONE: begin
                    cur_sel_o <= tgt;
                    err       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (state != ST_IDLE) | pending;
    assign err_o  = err;

endmodule

// File: tb/tb_vpll_reconfig_seq.sv
// Bench for vpll_reconfig_seq: Avalon stall/lock model, write scoreboard, vector table
// plus hand sequences for reset reload, queued request, glitch and mid-sequence reset.
module tb_vpll_reconfig_seq;

    logic        CLK_50M = 1'b0;
    logic        reset;
    logic [1:0]  sel_i;
    logic        force_i;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_write;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b0;
    logic        busy_o, done_o, err_o;
    logic [1:0]  cur_sel_o;

    always #10 CLK_50M = ~CLK_50M;

    vpll_reconfig_seq #(
        .NUM_PROFILES(4), .MIF_STRIDE(64), .ADDR_W(6), .DATA_W(32),
        .MIF_REG(31), .START_REG(2), .LOCK_TIMEOUT(100), .RETRIES(2)
    ) dut (
        .CLK_50M(CLK_50M), .reset(reset), .sel_i(sel_i), .force_i(force_i),
        .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
        .mgmt_write(mgmt_write), .mgmt_waitrequest(mgmt_waitrequest),
        .pll_locked(pll_locked), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .cur_sel_o(cur_sel_o)
    );

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [1:0] sel;
        bit         frc;
        int         stall;
        bit         lock;
        int         pairs;
        int         exp_cur;
        int         exp_err;
        int         exp_done;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[7];
    int   tests = 0;
    int   fails = 0;
    int   stall_len = 0;
    bit   lock_en = 1'b1;
    int   stall_cnt = 0;
    int   lock_timer = 0;
    bit   prev_acc = 1'b0;
    bit   holding = 1'b0;
    bit   in_start = 1'b0;
    int   done_cnt = 0;
    int   start_acc = 0;
    int   write_acc = 0;
    logic [5:0]  hold_addr;
    logic [31:0] hold_data;

    task automatic check_output(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic push_pair(input int tgt);
        wr_t w;
        w.addr = 6'd31;
        w.data = 32'(tgt * 64);
        exp_q.push_back(w);
        w.addr = 6'd2;
        w.data = 32'd0;
        exp_q.push_back(w);
    endtask

    task automatic step();
        @(posedge CLK_50M);
        #5;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n;
        n = 0;
        while (!busy_o && n < 40) begin
            step();
            n++;
        end
        n = 0;
        while (busy_o && n < max_cycles) begin
            step();
            n++;
        end
        check_output({name, "_idle"}, int'(busy_o), 0);
    endtask

    // Avalon slave + PLL model: stalls each write, scores accepts, raises lock after start.
    initial begin
        forever begin
            @(negedge CLK_50M);
            if (done_o) done_cnt++;
            if (prev_acc) check_output("gap_no_write", int'(mgmt_write), 0);
            prev_acc = 1'b0;
            in_start = mgmt_write && (mgmt_address == 6'd2);
            if (mgmt_write) begin
                if (holding) begin
                    check_output("stall_addr", int'(mgmt_address), int'(hold_addr));
                    check_output("stall_data", int'(mgmt_writedata), int'(hold_data));
                end
                if (stall_cnt < stall_len) begin
                    mgmt_waitrequest = 1'b1;
                    stall_cnt++;
                    holding   = 1'b1;
                    hold_addr = mgmt_address;
                    hold_data = mgmt_writedata;
                end else begin
                    mgmt_waitrequest = 1'b0;
                    stall_cnt = 0;
                    holding   = 1'b0;
                    prev_acc  = 1'b1;
                    write_acc++;
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_write_addr", int'(mgmt_address), 0);
                    end else begin
                        wr_t w;
                        w = exp_q.pop_front();
                        check_output("write_addr", int'(mgmt_address), int'(w.addr));
                        check_output("write_data", int'(mgmt_writedata), int'(w.data));
                    end
                    if (mgmt_address == 6'd2) begin
                        start_acc++;
                        lock_timer = 10;
                    end else begin
                        pll_locked = 1'b0;
                        lock_timer = 0;
                    end
                end
            end else begin
                mgmt_waitrequest = 1'b0;
                stall_cnt = 0;
                holding   = 1'b0;
                if (lock_timer > 0) begin
                    lock_timer--;
                    if (lock_timer == 0 && lock_en) pll_locked = 1'b1;
                end
            end
        end
    end

    initial begin
        #(20 * 60000);
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s, n, wa;
        bit busy_seen;

        vecs[0] = '{sel: 2'd2, frc: 0, stall: 5, lock: 1, pairs: 1, exp_cur: 2, exp_err: 0, exp_done: 1};
        vecs[1] = '{sel: 2'd3, frc: 0, stall: 0, lock: 1, pairs: 1, exp_cur: 3, exp_err: 0, exp_done: 1};
        vecs[2] = '{sel: 2'd0, frc: 0, stall: 2, lock: 1, pairs: 1, exp_cur: 0, exp_err: 0, exp_done: 1};
        vecs[3] = '{sel: 2'd0, frc: 1, stall: 0, lock: 1, pairs: 1, exp_cur: 0, exp_err: 0, exp_done: 1};
        vecs[4] = '{sel: 2'd2, frc: 0, stall: 0, lock: 0, pairs: 3, exp_cur: 0, exp_err: 1, exp_done: 0};
        vecs[5] = '{sel: 2'd2, frc: 1, stall: 0, lock: 1, pairs: 1, exp_cur: 2, exp_err: 0, exp_done: 1};
        vecs[6] = '{sel: 2'd1, frc: 0, stall: 1, lock: 1, pairs: 1, exp_cur: 1, exp_err: 0, exp_done: 1};

        // Reset with sel 2: reset values, then the automatic reload to profile 2.
        reset   = 1'b1;
        sel_i   = 2'd2;
        force_i = 1'b0;
        repeat (3) step();
        check_output("rst_write", int'(mgmt_write), 0);
        check_output("rst_addr", int'(mgmt_address), 0);
        check_output("rst_data", int'(mgmt_writedata), 0);
        check_output("rst_busy", int'(busy_o), 1);
        check_output("rst_done", int'(done_o), 0);
        check_output("rst_err", int'(err_o), 0);
        check_output("rst_cur", int'(cur_sel_o), 0);
        push_pair(2);
        done_cnt = 0;
        reset = 1'b0;
        wait_idle("boot", 500);
        check_output("boot_cur", int'(cur_sel_o), 2);
        check_output("boot_err", int'(err_o), 0);
        check_output("boot_done", done_cnt, 1);
        check_output("boot_queue", exp_q.size(), 0);

        // New request while waiting for lock is queued and served afterwards.
        push_pair(1);
        push_pair(3);
        done_cnt = 0;
        s = start_acc;
        sel_i = 2'd1;
        n = 0;
        while (start_acc == s && n < 100) begin
            step();
            n++;
        end
        check_output("queue_start_seen", start_acc, s + 1);
        sel_i = 2'd3;
        wait_idle("queue", 1000);
        check_output("queue_done", done_cnt, 2);
        check_output("queue_cur", int'(cur_sel_o), 3);
        check_output("queue_queue", exp_q.size(), 0);

        // A one-cycle sel glitch must not start anything.
        wa = write_acc;
        busy_seen = 1'b0;
        sel_i = 2'd0;
        step();
        sel_i = 2'd3;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy_o) busy_seen = 1'b1;
        end
        check_output("glitch_busy", int'(busy_seen), 0);
        check_output("glitch_writes", write_acc, wa);
        check_output("glitch_cur", int'(cur_sel_o), 3);

        // Reset while the start write is stalled; the reload re-issues the full sequence.
        stall_len = 5;
        wr_t_push_mif: begin
            wr_t w;
            w.addr = 6'd31;
            w.data = 32'd64;
            exp_q.push_back(w);
        end
        sel_i = 2'd1;
        n = 0;
        while (!in_start && n < 100) begin
            step();
            n++;
        end
        check_output("midrst_in_start", int'(in_start), 1);
        reset = 1'b1;
        step();
        check_output("midrst_write", int'(mgmt_write), 0);
        check_output("midrst_addr", int'(mgmt_address), 0);
        check_output("midrst_busy", int'(busy_o), 1);
        check_output("midrst_cur", int'(cur_sel_o), 0);
        push_pair(1);
        done_cnt = 0;
        reset = 1'b0;
        wait_idle("midrst", 1000);
        check_output("midrst_done", done_cnt, 1);
        check_output("midrst_final_cur", int'(cur_sel_o), 1);
        check_output("midrst_queue", exp_q.size(), 0);

        // Vector table: profile changes, stalls, forced reload, timeout and recovery.
        for (int i = 0; i < 7; i++) begin
            stall_len = vecs[i].stall;
            lock_en   = vecs[i].lock;
            done_cnt  = 0;
            for (int p = 0; p < vecs[i].pairs; p++) push_pair(int'(vecs[i].sel));
            sel_i = vecs[i].sel;
            if (vecs[i].frc) begin
                force_i = 1'b1;
                repeat (4) step();
                force_i = 1'b0;
            end
            wait_idle($sformatf("vec%0d", i), 2000);
            check_output($sformatf("vec%0d_cur", i), int'(cur_sel_o), vecs[i].exp_cur);
            check_output($sformatf("vec%0d_err", i), int'(err_o), vecs[i].exp_err);
            check_output($sformatf("vec%0d_done", i), done_cnt, vecs[i].exp_done);
            check_output($sformatf("vec%0d_queue", i), exp_q.size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vpll_reconfig_seq.md
# vpll_reconfig_seq

Parametrised sequencer that retunes the video PLL through the Altera PLL-reconfig management port whenever the core requests a different pixel base clock. It sits in the emu top level on CLK_50M, between the core's base-clock select (from the clk_32m domain) and the `altera_pll_reconfig_top` mgmt interface. It generalises the single-purpose inline sequencer with:
- N profiles and a configurable MIF stride;
- a forced-reload input;
- lock-wait with timeout and bounded retries;
- request queueing while a sequence is in flight.

## Interface
Parameters:
- NUM_PROFILES, 4, number of MIF profiles; select width SEL_W = max(1, clog2(NUM_PROFILES)).
- MIF_STRIDE, 64, MIF word offset between profiles; MIF base = sel*MIF_STRIDE.
- ADDR_W, 6, mgmt address width.
- DATA_W, 32, mgmt data width.
- MIF_REG, 31, mgmt address of the MIF-base register.
- START_REG, 2, mgmt address of the start register.
- LOCK_TIMEOUT, 1048576, CLK_50M cycles to wait for lock after start.
- RETRIES, 2, extra attempts after a timeout.

Ports:
- CLK_50M, in, 1, clock; all logic on rising edge.
- reset, in, 1, synchronous, active-high.
- sel_i, in, SEL_W, requested profile, asynchronous to CLK_50M.
- force_i, in, 1, level; a rising edge requests a reload of the current sel.
- mgmt_address, out, ADDR_W, Avalon-MM address.
- mgmt_writedata, out, DATA_W, Avalon-MM write data.
- mgmt_write, out, 1, Avalon-MM write strobe.
- mgmt_waitrequest, in, 1, Avalon-MM stall.
- pll_locked, in, 1, video PLL lock, asynchronous.
- busy_o, out, 1, sequence in progress.
- done_o, out, 1, one-cycle pulse when a profile is locked.
- err_o, out, 1, sticky: all attempts timed out.
- cur_sel_o, out, SEL_W, last successfully applied profile.

## Operation
- sel_i, force_i and pll_locked each pass through a 2-flop synchroniser.
- A request is raised by either:
  - the synchronised sel holding the same value for 2 consecutive cycles while differing from cur_sel_o; or
  - a rising edge of synchronised force.
- Request latch: a single pending flag plus target register. A newer request overwrites the target; no FIFO.
- After reset, pending = 1 with target = synchronised sel, once that sel is valid (3 cycles). Every reset therefore reconfigures once.
- Sel values ≥ NUM_PROFILES are clamped to NUM_PROFILES-1.
- FSM states:
  - IDLE: pending → WR_MIF. Latch tgt, clear pending, attempt := 0.
  - WR_MIF: address = MIF_REG, data = tgt*MIF_STRIDE zero-extended, write = 1. Leave when waitrequest = 0 → GAP.
  - GAP: one cycle, write = 0 → WR_START.
  - WR_START: address = START_REG, data = 0, write = 1. Leave when waitrequest = 0 → WAIT_LOCK, with the timer cleared.
  - WAIT_LOCK: timer increments. Synchronised pll_locked = 1 for 4 consecutive cycles → DONE. Timer = LOCK_TIMEOUT-1 → RETRY.
  - RETRY: attempt < RETRIES → attempt+1, WR_MIF. Otherwise err_o := 1 → IDLE, with cur_sel_o unchanged.
  - DONE: cur_sel_o := tgt, err_o := 0, done_o = 1 → IDLE.
- busy_o = (state != IDLE) | pending.
- Requests arriving outside IDLE only update pending/target. They are served after DONE or after retries are exhausted, never by aborting a sequence.
- A request whose target equals the in-flight tgt, with no force edge, is dropped.

## Timing
- Reset values:
  - state IDLE
  - mgmt_write 0, mgmt_address 0, mgmt_writedata 0
  - busy_o 1 (pending set), done_o 0, err_o 0, cur_sel_o 0
  - timer 0, attempt 0
- Avalon rule: mgmt_write, address and data stay stable until the cycle in which waitrequest = 0. That cycle is the accept cycle, and write deasserts in the next cycle.
- Latency with waitrequest = 0 throughout:
  - WR_MIF, GAP and WR_START take 1 cycle each.
  - Lock confirmation needs at least 4 cycles after the synchronised lock goes high.
  - done_o asserts the cycle after confirmation.
- mgmt_write is never asserted in two consecutive accepted cycles; GAP guarantees this.
- Reset mid-sequence: the next cycle shows reset values. A write already in flight is abandoned, and the after-reset reload re-issues the full sequence.
- Timer width = clog2(LOCK_TIMEOUT) + 1. The timer does not wrap; it is cleared on WR_START accept.
- A lock drop during WAIT_LOCK resets the 4-cycle confirm counter, not the timer.

## Test plan
- Reset, sel_i = 2, waitrequest = 0, lock asserted 10 cycles after start: writes (31, 0x80) then (2, 0); done_o pulses once; cur_sel_o = 2; busy_o = 0.
- waitrequest held high for 5 cycles on each write: address and data stay stable, each write is accepted exactly once, and no write is issued in GAP.
- sel_i changes 1→3 during WAIT_LOCK of profile 1: profile 1 completes (done_o), then the sequence for 3 follows with MIF data 0xC0; cur_sel_o ends at 3.
- pll_locked never asserts with LOCK_TIMEOUT = 100 and RETRIES = 2: 3 full write pairs are issued, err_o = 1 after about 300 cycles, cur_sel_o is unchanged; a later successful sequence clears err_o.
- force_i rising edge with sel_i equal to cur_sel_o: one full sequence is issued. A sel_i glitch lasting 1 cycle triggers nothing.
- reset asserted during WR_START: the next cycle has mgmt_write = 0 and state IDLE; after release a full sequence to the current sel runs.
